// File: rtl/usart_receiver_if.sv
// rtl/usart_receiver_if.sv - byte-receive handshake and serial line bundle for usart_receiver
interface usart_receiver_if;
   logic [15:0] baud_div;
   logic        rx;
   logic        rx_ack;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        overrun;
   logic        frame_error;
   logic        busy;

   // consumer side: drives the line, the divisor and the acknowledge
   modport master (
      output baud_div, rx, rx_ack,
      input  rx_data, rx_ready, overrun, frame_error, busy
   );

   // receiver side
   modport slave (
      input  baud_div, rx, rx_ack,
      output rx_data, rx_ready, overrun, frame_error, busy
   );
endinterface

// File: rtl/usart_receiver.sv
// rtl/usart_receiver.sv - 8N1 serial receiver with ready/ack holding register
module usart_receiver (
   input logic             clock,
   input logic             reset,
   usart_receiver_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        rx_meta;
   logic        rxs;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shreg;
   logic [15:0] div_q;
   logic [15:0] half_m1;
   logic [15:0] full_m1;

   logic [7:0]  data_q;
   logic        ready_q;
   logic        overrun_q;
   logic        ferr_q;

   logic        start_go;
   logic        cnt_clr;
   logic        bit_take;
   logic        good_stop;
   logic        bad_stop;

   assign half_m1 = (div_q >> 1) - 16'd1;
   assign full_m1 = div_q - 16'd1;

   // two-flop synchronizer for the asynchronous line, idles high
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rxs     <= rx_meta;
      end
   end

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // next-state decode and per-cycle datapath strobes
   always_comb begin
      state_next = state;
      start_go   = 1'b0;
      cnt_clr    = 1'b0;
      bit_take   = 1'b0;
      good_stop  = 1'b0;
      bad_stop   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxs) begin
               start_go   = 1'b1;
               state_next = S_START;
            end
         end
         S_START: begin
            if (cnt == half_m1) begin
               cnt_clr    = 1'b1;
               state_next = rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == full_m1) begin
               cnt_clr  = 1'b1;
               bit_take = 1'b1;
               if (idx == 3'd7) state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt == full_m1) begin
               cnt_clr = 1'b1;
               if (rxs) begin
                  good_stop  = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  bad_stop   = 1'b1;
                  state_next = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rxs) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // bit timing counter, data index, shift register and latched divisor
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt   <= 16'd0;
         idx   <= 3'd0;
         shreg <= 8'd0;
         div_q <= 16'd0;
      end else begin
         if (start_go) begin
            cnt   <= 16'd0;
            div_q <= bus.baud_div;
         end else if (cnt_clr) begin
            cnt <= 16'd0;
         end else if (state != S_IDLE && state != S_BREAK) begin
            cnt <= cnt + 16'd1;
         end
         if (state == S_START && cnt_clr) idx <= 3'd0;
         else if (bit_take)               idx <= idx + 3'd1;
         if (bit_take) shreg[idx] <= rxs;
      end
   end

   // holding register: a landing byte beats a simultaneous ack
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q    <= 8'd0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         ferr_q <= bad_stop;
         if (good_stop) begin
            data_q    <= shreg;
            ready_q   <= 1'b1;
            overrun_q <= bus.rx_ack ? 1'b0 : (ready_q | overrun_q);
         end else if (bus.rx_ack && ready_q) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.rx_data     = data_q;
   assign bus.rx_ready    = ready_q;
   assign bus.overrun     = overrun_q;
   assign bus.frame_error = ferr_q;
   assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_usart_receiver.sv
// tb/tb_usart_receiver.sv - scenario bench with expected-byte scoreboard for usart_receiver
module tb_usart_receiver;

   logic clock = 1'b0;
   logic reset = 1'b1;

   usart_receiver_if bus ();

   usart_receiver dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int errors   = 0;
   int fe_count = 0;
   logic [7:0] exp_q[$];

   // frame_error pulses seen on the output
   always @(negedge clock) begin
      if (bus.frame_error === 1'b1) fe_count++;
   end

   // drive one frame starting at the current negedge, ends on a negedge
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
      bus.rx = 1'b0;
      repeat (div) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (div) @(negedge clock);
      end
      bus.rx = stop_bit;
      repeat (div) @(negedge clock);
      if (stop_bit) exp_q.push_back(b);
   endtask

   task automatic wait_ready(input int budget, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < budget) begin
         if (bus.rx_ready === 1'b1) ok = 1'b1;
         else begin
            @(negedge clock);
            n++;
         end
      end
   endtask

   // newest expected byte; older ones were overwritten in the holding register
   function automatic logic [7:0] sb_last();
      logic [7:0] v;
      v = 8'hxx;
      while (exp_q.size() > 0) v = exp_q.pop_front();
      return v;
   endfunction

   task automatic pulse_ack();
      bus.rx_ack = 1'b1;
      @(negedge clock);
      bus.rx_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
      checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b want 0", bus.frame_error); end
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_single_byte();
      int fe0;
      bit ok;
      logic [7:0] e;
      fe0 = fe_count;
      bus.baud_div = 16'd16;
      @(negedge clock);
      send_frame(8'h43, 1'b1, 16);
      wait_ready(64, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_ready_timeout got 0 want 1"); end
      e = sb_last();
      checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL single_rx_data got %h want %h", bus.rx_data, e); end
      checks++; if (fe_count !== fe0) begin errors++; $display("FAIL single_frame_error got %0d want %0d", fe_count - fe0, 0); end
      pulse_ack();
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL single_ack_ready got %b want 0", bus.rx_ready); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [7:0] e;
      bus.baud_div = 16'd16;
      @(negedge clock);
      send_frame(8'hA5, 1'b1, 16);
      send_frame(8'h3C, 1'b1, 16);
      wait_ready(64, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_ready_timeout got 0 want 1"); end
      e = sb_last();
      checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL b2b_rx_data got %h want %h", bus.rx_data, e); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", bus.overrun); end
      pulse_ack();
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ack_ready got %b want 0", bus.rx_ready); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_ack_overrun got %b want 0", bus.overrun); end
   endtask

   task automatic test_glitch();
      int fe0;
      bit seen_busy;
      logic [7:0] d0;
      fe0 = fe_count;
      d0 = bus.rx_data;
      seen_busy = 1'b0;
      bus.baud_div = 16'd16;
      @(negedge clock);
      bus.rx = 1'b0;
      repeat (5) begin
         @(negedge clock);
         if (bus.busy === 1'b1) seen_busy = 1'b1;
      end
      bus.rx = 1'b1;
      repeat (30) begin
         @(negedge clock);
         if (bus.busy === 1'b1) seen_busy = 1'b1;
      end
      checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got %b want 1", seen_busy); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", bus.busy); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL glitch_rx_ready got %b want 0", bus.rx_ready); end
      checks++; if (bus.rx_data !== d0) begin errors++; $display("FAIL glitch_rx_data got %h want %h", bus.rx_data, d0); end
      checks++; if (fe_count !== fe0) begin errors++; $display("FAIL glitch_frame_error got %0d want 0", fe_count - fe0); end
   endtask

   task automatic test_frame_error();
      int fe0;
      bit ok;
      logic [7:0] e;
      fe0 = fe_count;
      bus.baud_div = 16'd16;
      @(negedge clock);
      send_frame(8'h55, 1'b0, 16);
      repeat (40 * 16) @(negedge clock);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got %b want 1", bus.busy); end
      bus.rx = 1'b1;
      repeat (8) @(negedge clock);
      checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse_count got %0d want 1", fe_count - fe0); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL ferr_rx_ready got %b want 0", bus.rx_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got %b want 0", bus.busy); end
      send_frame(8'h81, 1'b1, 16);
      wait_ready(64, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ferr_next_timeout got 0 want 1"); end
      e = sb_last();
      checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL ferr_next_rx_data got %h want %h", bus.rx_data, e); end
      pulse_ack();
   endtask

   task automatic test_collision();
      bit ok;
      logic [7:0] e;
      bus.baud_div = 16'd1250;
      @(negedge clock);
      send_frame(8'h12, 1'b1, 1250);
      wait_ready(5000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL coll_first_timeout got 0 want 1"); end
      fork
         send_frame(8'h9E, 1'b1, 1250);
         begin
            repeat (2 + 625 + 9 * 1250) @(negedge clock);
            bus.rx_ack = 1'b1;
            @(negedge clock);
            bus.rx_ack = 1'b0;
         end
      join
      e = sb_last();
      checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL coll_rx_ready got %b want 1", bus.rx_ready); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun got %b want 0", bus.overrun); end
      checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL coll_rx_data got %h want %h", bus.rx_data, e); end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      logic [7:0] e;
      logic [7:0] b;
      b = 8'hA7;
      bus.baud_div = 16'd16;
      @(negedge clock);
      bus.rx = 1'b0;
      repeat (16) @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         bus.rx = b[i];
         repeat ((i == 4) ? 8 : 16) @(negedge clock);
      end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", bus.busy); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data got %h want 00", bus.rx_data); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_ready got %b want 0", bus.rx_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got %b want 0", bus.overrun); end
      @(negedge clock);
      bus.rx = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      exp_q.delete();
      send_frame(8'hFF, 1'b1, 16);
      wait_ready(64, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_mid_next_timeout got 0 want 1"); end
      e = sb_last();
      checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL rst_mid_next_rx_data got %h want %h", bus.rx_data, e); end
   endtask

   initial begin
      bus.rx       = 1'b1;
      bus.rx_ack   = 1'b0;
      bus.baud_div = 16'd16;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_collision();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/usart_receiver.md
# usart_receiver

Standalone serial receiver for the USART path: recovers 8N1 frames from the `rx` pin and presents each byte through a ready/ack holding register. It shares its bit-period divisor convention with the transmitter (clocks per bit, e.g. 1250). It is the receive-side counterpart used by the loopback and tester top levels to check bytes emitted by the transmitter.

## Interface
- No parameters; bit period comes from the `baud_div` port.
- `clock` input 1: system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `baud_div` input 16: clock cycles per bit.
  - Legal range 4..65535.
  - Captured at the start of each frame; changes mid-frame have no effect until the next frame.
- `rx` input 1: serial line, idle high, asynchronous to `clock`.
- `rx_data` output 8: last good byte; held until overwritten.
- `rx_ready` output 1: level; high when `rx_data` holds an unacknowledged byte.
- `rx_ack` input 1: one-cycle pulse from consumer; clears `rx_ready`.
- `overrun` output 1: sticky; set when a good byte lands while `rx_ready`=1; cleared by `rx_ack`.
- `frame_error` output 1: one-cycle pulse when a stop bit is sampled low.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rx` passes through two flops (reset value 1). All decisions use the synchronized value `rxs`.
- **Bit counter:** 16-bit bit counter `cnt`; 3-bit data index; 8-bit shift register, LSB first; `div_q` holds the latched `baud_div`.
- **State machine:**
  - IDLE → START when `rxs`=0. On that edge: `cnt`←0, `div_q`←`baud_div`.
  - START: `cnt` increments each cycle. When `cnt` = (`div_q`>>1)−1, sample `rxs`.
    - Sample is 0: go to DATA with `cnt`←0 and index←0.
    - Sample is 1 (glitch or false start): go to IDLE; no output change.
  - DATA: when `cnt` = `div_q`−1, shift `rxs` into bit[index] and set `cnt`←0. After index 7 is sampled, go to STOP.
  - STOP: when `cnt` = `div_q`−1, sample `rxs`.
    - Sample is 1: `rx_data`←shift register, `rx_ready`←1, `overrun`←`rx_ready` OR `overrun` (pre-update value); go to IDLE.
    - Sample is 0: pulse `frame_error`; `rx_data`, `rx_ready` and `overrun` are untouched; go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE. A held-low line therefore produces exactly one `frame_error`, not repeated frames.
- **`rx_ack` handling:**
  - With `rx_ack` alone, the next edge clears `rx_ready` and `overrun`.
  - If `rx_ack` coincides with a good-stop edge, the new byte wins: `rx_ready` stays 1, `overrun` ends at 0, and `rx_data` gets the new byte.
  - `rx_ack` while `rx_ready`=0 is ignored.
- **Reset** (at any time, including mid-frame):
  - State→IDLE; `cnt`, index, shift register and `div_q`→0; synchronizer→1.
  - Outputs: `rx_data`=0x00, `rx_ready`=0, `overrun`=0, `frame_error`=0, `busy`=0.
  - A frame in progress at reset release is not recovered. If `rx` is still low after release, the receiver enters START and rejects or decodes according to the rules above.

## Timing
- Synchronizer latency is 2 cycles from the pin to `rxs`.
- Define E as the edge on which IDLE sees `rxs`=0, with div=`div_q` and h=div>>1.
  - Start bit sampled at E+h.
  - Data bit k (k=0..7) sampled at E+h+(k+1)·div.
  - Stop bit sampled at E+h+9·div.
  - `rx_ready`, `rx_data` or `frame_error` update on that stop-sample edge, visible the following cycle.
- `busy` rises one cycle after E. It falls in the cycle after the stop sample, or after a rejected start, or on BREAK exit.
- A new start bit can be detected on the first IDLE cycle after STOP. Back-to-back frames with no idle gap are received without loss.
- Sampling lands at mid-bit ±1 cycle for even or odd div. Frames are tolerated with cumulative transmitter clock error up to about ±4%.

## Test plan
- **Single byte:** div=16, send 0x43 (8N1) → one frame later `rx_ready`=1 and `rx_data`=0x43, `frame_error` never pulses. Pulse `rx_ack` → `rx_ready`=0 next cycle.
- **Back-to-back with overrun:** div=16, send 0xA5 then 0x3C back-to-back with no ack → `rx_data`=0x3C, `overrun`=1. Then `rx_ack` → `rx_ready`=0 and `overrun`=0.
- **Glitch rejection:** div=16, drive `rx` low for 5 cycles then high → `busy` pulses, then IDLE; `rx_ready`, `rx_data` and `frame_error` unchanged.
- **Framing error and break:** div=16, send 0x55 with stop bit low, then hold `rx` low for 40 bit times → exactly one `frame_error` pulse, `rx_ready` stays 0. Return to IDLE after `rx` goes high; a following 0x81 is received correctly.
- **Ack/byte collision:** div=1250, assert `rx_ack` on the exact stop-sample edge of the second byte → `rx_ready`=1, `overrun`=0, `rx_data`=second byte.
- **Reset mid-frame:** assert `reset` during data bit 4 → all outputs return to reset values immediately (asynchronous). After release with `rx` high, a fresh 0xFF frame is received correctly.
